j_syncreg_wrarb: RTL and testbench

//  Write arbiter/sequencer for a bank of NREG 16-bit load-enabled sync registers (j_fdsync16 instances).

---
 rtl/j_syncreg_wrarb.sv | 101 ++++++++++
 tb/tb_j_syncreg_wrarb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/j_syncreg_wrarb.sv
// Round-robin write arbiter for a bank of 16-bit load-enabled sync registers.
// One register write per cycle; a requester granted last cycle is masked for this cycle.
module j_syncreg_wrarb #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned NREG = 8,
    parameter int unsigned AW   = 3
) (
    input  logic                 sys_clk,
    input  logic                 resetl,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*16-1:0]   req_data,
    input  logic                 freeze,
    output logic [NREQ-1:0]      gnt,
    output logic [NREG-1:0]      ld,
    output logic [15:0]          dout,
    output logic                 err,
    output logic                 busy
);

    localparam int unsigned DW = 16;
    localparam int unsigned PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, FROZEN} state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] elig;
    logic [PW-1:0]   scan_idx;
    logic [PW-1:0]   win_idx;
    logic            win_vld;
    logic [AW-1:0]   win_addr;
    logic            win_legal;
    logic [NREG-1:0] win_ld;
    logic [AW-1:0]   addr_a [NREQ];
    logic [DW-1:0]   data_a [NREQ];

    for (genvar i = 0; i < int'(NREQ); i++) begin : g_unpack
        assign addr_a[i] = req_addr[i*AW +: AW];
        assign data_a[i] = req_data[i*DW +: DW];
    end

    // gnt is only ever nonzero while in ISSUE, so it doubles as the mask there
    assign mask = (state == ISSUE) ? gnt : '0;
    assign elig = req & ~mask;
    assign busy = |elig;

    // First eligible requester scanning from rr_ptr, wrapping mod NREQ
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = PW'((32'(rr_ptr) + k) % NREQ);
            if (!win_vld && elig[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    // Decode the winner's address into a load strobe; out-of-range gives no strobe
    always_comb begin
        win_addr  = addr_a[win_idx];
        win_legal = 32'(win_addr) < NREG;
        win_ld    = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            win_ld[r] = win_legal && (32'(win_addr) == r);
        end
    end

    // Output stage: strobes are one-cycle pulses, dout holds between issues
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state  <= IDLE;
            gnt    <= '0;
            ld     <= '0;
            dout   <= '0;
            err    <= 1'b0;
            rr_ptr <= '0;
        end else begin
            gnt <= '0;
            ld  <= '0;
            err <= 1'b0;
            if (freeze) begin
                state <= FROZEN;
            end else if (win_vld) begin
                state  <= ISSUE;
                gnt    <= NREQ'(1) << win_idx;
                ld     <= win_ld;
                err    <= !win_legal;
                dout   <= data_a[win_idx];
                rr_ptr <= PW'((32'(win_idx) + 1) % NREQ);
            end else begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_j_syncreg_wrarb.sv
// Directed bench for j_syncreg_wrarb: per-cycle vector table plus reset and
// illegal-address sequences on a second, smaller-bank instance.
module tb_j_syncreg_wrarb;

    logic        sys_clk;
    logic        resetl;
    logic [2:0]  req;
    logic [8:0]  req_addr;
    logic [47:0] req_data;
    logic        freeze;
    logic [2:0]  gnt;
    logic [7:0]  ld;
    logic [15:0] dout;
    logic        err;
    logic        busy;

    logic [2:0]  req_b;
    logic [11:0] addr_b;
    logic [47:0] data_b;
    logic        freeze_b;
    logic [2:0]  gnt_b;
    logic [5:0]  ld_b;
    logic [15:0] dout_b;
    logic        err_b;
    logic        busy_b;

    int checks = 0;
    int errors = 0;

    j_syncreg_wrarb #(.NREQ(3), .NREG(8), .AW(3)) dut (
        .sys_clk(sys_clk), .resetl(resetl), .req(req), .req_addr(req_addr),
        .req_data(req_data), .freeze(freeze), .gnt(gnt), .ld(ld), .dout(dout),
        .err(err), .busy(busy)
    );

    j_syncreg_wrarb #(.NREQ(3), .NREG(6), .AW(4)) dut_b (
        .sys_clk(sys_clk), .resetl(resetl), .req(req_b), .req_addr(addr_b),
        .req_data(data_b), .freeze(freeze_b), .gnt(gnt_b), .ld(ld_b), .dout(dout_b),
        .err(err_b), .busy(busy_b)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [2:0]  req;
        logic [8:0]  addr;
        logic [47:0] data;
        logic        frz;
        logic        busy;
        logic [2:0]  gnt;
        logic [7:0]  ld;
        logic [15:0] dout;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [2:0] rq,
                                input logic [2:0] a2, input logic [2:0] a1, input logic [2:0] a0,
                                input logic [15:0] d2, input logic [15:0] d1, input logic [15:0] d0,
                                input logic fz, input logic bz, input logic [2:0] g,
                                input logic [7:0] l, input logic [15:0] o, input logic e);
        vec_t v;
        v.req  = rq;
        v.addr = {a2, a1, a0};
        v.data = {d2, d1, d0};
        v.frz  = fz;
        v.busy = bz;
        v.gnt  = g;
        v.ld   = l;
        v.dout = o;
        v.err  = e;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Rows: inputs for cycle N, busy seen in N, gnt/ld/dout/err seen in N+1
        //   req    a2 a1 a0  d2       d1       d0       fz bz gnt     ld      dout     err
        add(3'b111, 6, 3, 1, 16'hA002, 16'hA001, 16'hA000, 0, 1, 3'b001, 8'h02, 16'hA000, 0);
        add(3'b110, 6, 3, 1, 16'hA002, 16'hA001, 16'hA000, 0, 1, 3'b010, 8'h08, 16'hA001, 0);
        add(3'b100, 6, 3, 1, 16'hA002, 16'hA001, 16'hA000, 0, 1, 3'b100, 8'h40, 16'hA002, 0);
        add(3'b100, 6, 3, 1, 16'hA002, 16'hA001, 16'hA000, 0, 0, 3'b000, 8'h00, 16'hA002, 0);
        add(3'b001, 0, 0, 2, 16'h0000, 16'h0000, 16'h1234, 0, 1, 3'b001, 8'h04, 16'h1234, 0);
        add(3'b000, 0, 0, 2, 16'h0000, 16'h0000, 16'h1234, 0, 0, 3'b000, 8'h00, 16'h1234, 0);
        add(3'b011, 0, 1, 0, 16'h0000, 16'hB100, 16'hB000, 0, 1, 3'b010, 8'h02, 16'hB100, 0);
        add(3'b011, 0, 1, 0, 16'h0000, 16'hB101, 16'hB000, 0, 1, 3'b001, 8'h01, 16'hB000, 0);
        add(3'b011, 0, 1, 0, 16'h0000, 16'hB101, 16'hB001, 0, 1, 3'b010, 8'h02, 16'hB101, 0);
        add(3'b011, 0, 1, 0, 16'h0000, 16'hB102, 16'hB001, 0, 1, 3'b001, 8'h01, 16'hB001, 0);
        add(3'b000, 0, 1, 0, 16'h0000, 16'hB102, 16'hB001, 0, 0, 3'b000, 8'h00, 16'hB001, 0);
        add(3'b010, 0, 4, 0, 16'h0000, 16'hC0DE, 16'h0000, 1, 1, 3'b000, 8'h00, 16'hB001, 0);
        add(3'b010, 0, 4, 0, 16'h0000, 16'hC0DE, 16'h0000, 1, 1, 3'b000, 8'h00, 16'hB001, 0);
        add(3'b010, 0, 4, 0, 16'h0000, 16'hC0DE, 16'h0000, 1, 1, 3'b000, 8'h00, 16'hB001, 0);
        add(3'b010, 0, 4, 0, 16'h0000, 16'hC0DE, 16'h0000, 0, 1, 3'b010, 8'h10, 16'hC0DE, 0);
        add(3'b000, 0, 4, 0, 16'h0000, 16'hC0DE, 16'h0000, 0, 0, 3'b000, 8'h00, 16'hC0DE, 0);
        add(3'b100, 5, 0, 0, 16'hD005, 16'h0000, 16'h0000, 0, 1, 3'b100, 8'h20, 16'hD005, 0);
        add(3'b000, 5, 0, 0, 16'hD005, 16'h0000, 16'h0000, 0, 0, 3'b000, 8'h00, 16'hD005, 0);
        add(3'b011, 0, 3, 3, 16'h0000, 16'hE001, 16'hE000, 0, 1, 3'b001, 8'h08, 16'hE000, 0);
        add(3'b010, 0, 3, 3, 16'h0000, 16'hE001, 16'hE000, 0, 1, 3'b010, 8'h08, 16'hE001, 0);
        add(3'b000, 0, 3, 3, 16'h0000, 16'hE001, 16'hE000, 0, 0, 3'b000, 8'h00, 16'hE001, 0);

        resetl   = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        freeze   = 1'b0;
        req_b    = '0;
        addr_b   = '0;
        data_b   = '0;
        freeze_b = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_gnt",  32'(gnt),  32'h0);
        chk("rst_ld",   32'(ld),   32'h0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_err",  32'(err),  32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge sys_clk);
        resetl = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            @(negedge sys_clk);
            req      = v.req;
            req_addr = v.addr;
            req_data = v.data;
            freeze   = v.frz;
            #1;
            chk($sformatf("r%0d_busy", i), 32'(busy), 32'(v.busy));
            @(posedge sys_clk);
            #1;
            chk($sformatf("r%0d_gnt", i),  32'(gnt),  32'(v.gnt));
            chk($sformatf("r%0d_ld", i),   32'(ld),   32'(v.ld));
            chk($sformatf("r%0d_dout", i), 32'(dout), 32'(v.dout));
            chk($sformatf("r%0d_err", i),  32'(err),  32'(v.err));
        end

        // Illegal address on the 6-register bank, then a legal follow-up write
        @(negedge sys_clk);
        req_b  = 3'b100;
        addr_b = {4'd7, 4'd0, 4'd0};
        data_b = {16'hD007, 32'h0};
        @(posedge sys_clk);
        #1;
        chk("ill_gnt", 32'(gnt_b), 32'h4);
        chk("ill_err", 32'(err_b), 32'h1);
        chk("ill_ld",  32'(ld_b),  32'h0);
        @(negedge sys_clk);
        addr_b = {4'd5, 4'd0, 4'd0};
        data_b = {16'hD105, 32'h0};
        @(posedge sys_clk);
        #1;
        chk("mask_gnt", 32'(gnt_b), 32'h0);
        chk("mask_err", 32'(err_b), 32'h0);
        @(posedge sys_clk);
        #1;
        chk("leg_gnt",  32'(gnt_b),  32'h4);
        chk("leg_ld",   32'(ld_b),   32'h20);
        chk("leg_dout", 32'(dout_b), 32'hD105);
        chk("leg_err",  32'(err_b),  32'h0);
        @(negedge sys_clk);
        req_b = '0;

        // Reset asserted mid-issue clears outputs at once and restarts rr at 0
        @(negedge sys_clk);
        req      = 3'b001;
        req_addr = {3'd0, 3'd0, 3'd1};
        req_data = {32'h0, 16'hF00F};
        @(posedge sys_clk);
        #1;
        chk("pre_gnt", 32'(gnt), 32'h1);
        #2;
        resetl = 1'b0;
        #1;
        chk("arst_gnt",  32'(gnt),  32'h0);
        chk("arst_ld",   32'(ld),   32'h0);
        chk("arst_dout", 32'(dout), 32'h0);
        chk("arst_err",  32'(err),  32'h0);
        req      = 3'b011;
        req_addr = {3'd0, 3'd2, 3'd1};
        req_data = {16'h0, 16'hF11F, 16'hF00F};
        @(negedge sys_clk);
        resetl = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("post_gnt",  32'(gnt),  32'h1);
        chk("post_ld",   32'(ld),   32'h02);
        chk("post_dout", 32'(dout), 32'hF00F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
